// File: rtl/fetch_unit.sv
// fetch_unit: PC, ROM addressing and prefetch queue feeding decode.
// Optional self-loop halt is built when `FETCH_HALT_EN is defined.
`ifndef PROG_WIDTH
`define PROG_WIDTH 12
`endif

module fetch_unit #(
  parameter int QDEPTH = 2,
  parameter int PC_W   = 4
) (
  input  logic                   clk,
  input  logic                   n_reset,
  output logic [PC_W-1:0]        rom_addr,
  input  logic [`PROG_WIDTH-1:0] rom_data,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_addr,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [`PROG_WIDTH-1:0] ir,
  output logic [PC_W-1:0]        ir_pc,
  output logic                   halted
);
  localparam int IW = `PROG_WIDTH;
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [PC_W-1:0] r_pc;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [IW-1:0]   r_ir_q [QDEPTH];
  logic [PC_W-1:0] r_pc_q [QDEPTH];

  logic w_pop;
  logic w_fetch;
  logic w_halt;
  logic w_self_loop;

`ifdef FETCH_HALT_EN
  logic r_halted;

  assign w_halt      = r_halted;
  assign w_self_loop = (rom_data[IW-1:IW-4] == 4'hF)
                     && (rom_data[PC_W-1:0] == r_pc);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      r_halted <= 1'b0;
    else if (redirect_valid)
      r_halted <= 1'b0;
    else if (w_fetch && w_self_loop)
      r_halted <= 1'b1;
  end
`else
  assign w_halt      = 1'b0;
  assign w_self_loop = 1'b0;
`endif

  assign halted   = w_halt;
  assign rom_addr = r_pc;
  assign ir_valid = (r_cnt != '0);
  assign w_pop    = ir_valid & ir_ready;
  assign w_fetch  = !redirect_valid && !w_halt
                  && ((r_cnt < FULL) || w_pop);

  // Head comes from registered storage only; forced to zero when empty.
  assign ir    = ir_valid ? r_ir_q[r_rd] : '0;
  assign ir_pc = ir_valid ? r_pc_q[r_rd] : '0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pc  <= '0;
      r_cnt <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_ir_q[i] <= '0;
        r_pc_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_pc  <= redirect_addr;
      r_cnt <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
    end else begin
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      if (w_fetch) begin
        r_ir_q[r_wr] <= rom_data;
        r_pc_q[r_wr] <= r_pc;
        r_wr         <= r_wr + AW'(1);
        if (!w_self_loop)
          r_pc <= r_pc + PC_W'(1);
      end
      r_cnt <= r_cnt + CW'(w_fetch) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit
// against a queue-based reference model.
`ifndef PROG_WIDTH
`define PROG_WIDTH 12
`endif

module tb_fetch_unit;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        n_reset;
  logic [3:0]  rom_addr;
  logic [11:0] rom_data;
  logic        redirect_valid;
  logic [3:0]  redirect_addr;
  logic        ir_valid;
  logic        ir_ready;
  logic [11:0] ir;
  logic [3:0]  ir_pc;
  logic        halted;

  logic [11:0] rom [16];
  logic [15:0] m_q [$];
  logic [3:0]  m_pc;
  bit          m_halt;
  int          n_chk;
  int          n_pass;

  fetch_unit #(.QDEPTH(2), .PC_W(4)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .ir(ir),
    .ir_pc(ir_pc),
    .halted(halted)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic load_prog();
    rom[0] = 12'h700;
    rom[1] = 12'h123;
    rom[2] = 12'h001;
    rom[3] = 12'h456;
    rom[4] = 12'h789;
    rom[5] = 12'hABC;
    for (int i = 6; i < 16; i++) rom[i] = 12'hF00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 4'h0;
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    m_q.delete();
    m_pc = 4'h0;
    m_halt = 1'b0;
  endtask

  // One clock: drive inputs, advance the reference model, land on negedge.
  task automatic tick(input bit rdy, input bit rv, input logic [3:0] ra);
    bit pop;
    bit full;
    logic [11:0] w;
    ir_ready = rdy;
    redirect_valid = rv;
    redirect_addr = ra;
    pop  = (m_q.size() != 0) && rdy;
    full = (m_q.size() >= 2);
    w    = rom[m_pc];
    @(posedge clk);
    if (rv) begin
      m_q.delete();
      m_pc = ra;
      m_halt = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_halt && (!full || pop)) begin
        m_q.push_back({m_pc, w});
        if (HALT_EN && w[11:8] == 4'hF && w[3:0] == m_pc) m_halt = 1'b1;
        else m_pc = m_pc + 4'd1;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    load_prog();
    @(negedge clk);
    n_reset = 1'b0;
    ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 4'h0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({ir_valid, ir, ir_pc, halted, rom_addr} !== 22'h0)
      $display("FAIL reset_outs: got v=%b ir=%h pc=%h h=%b a=%h want all 0",
               ir_valid, ir, ir_pc, halted, rom_addr);
    else n_pass++;
    @(negedge clk);
    n_reset = 1'b1;
    m_q.delete();
    m_pc = 4'h0;
    m_halt = 1'b0;
    #1;
    n_chk++;
    if (ir_valid !== 1'b0)
      $display("FAIL reset_release: ir_valid=%b want 0", ir_valid);
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 4'h0);
      n_chk++;
      if (ir_valid !== 1'b1 || ir_pc !== 4'(k) || ir !== rom[k])
        $display("FAIL stream_%0d: v=%b pc=%h ir=%h want v=1 pc=%h ir=%h",
                 k, ir_valid, ir_pc, ir, 4'(k), rom[k]);
      else n_pass++;
      if (k == 2) begin
        n_chk++;
        if (ir !== 12'h001)
          $display("FAIL stream_ir_pc2: ir=%h want 001", ir);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 4'h0);
    n_chk++;
    if (rom_addr !== 4'h2 || ir !== 12'h700 || ir_pc !== 4'h0 || !ir_valid)
      $display("FAIL stall_hold: a=%h ir=%h pc=%h v=%b want a=2 ir=700 pc=0 v=1",
               rom_addr, ir, ir_pc, ir_valid);
    else n_pass++;
    exp = 4'h1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 4'h0);
      n_chk++;
      if (ir_pc !== exp || ir !== rom[exp] || !ir_valid)
        $display("FAIL stall_release_%0d: pc=%h ir=%h want pc=%h ir=%h",
                 k, ir_pc, ir, exp, rom[exp]);
      else n_pass++;
      exp = exp + 4'd1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 4'h9);
    n_chk++;
    if (ir_valid !== 1'b0 || rom_addr !== 4'h9)
      $display("FAIL redirect_flush: v=%b a=%h want v=0 a=9", ir_valid, rom_addr);
    else n_pass++;
    tick(1'b1, 1'b0, 4'h0);
    n_chk++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'h9 || ir !== rom[9])
      $display("FAIL redirect_target: v=%b pc=%h ir=%h want v=1 pc=9 ir=%h",
               ir_valid, ir_pc, ir, rom[9]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      tick(1'b1, 1'b0, 4'h0);
      if (k >= 16) begin
        n_chk++;
        if (ir_pc !== 4'(k - 1) || !ir_valid)
          $display("FAIL wrap_%0d: pc=%h v=%b want pc=%h v=1",
                   k, ir_pc, ir_valid, 4'(k - 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_halt();
    load_prog();
    rom[5] = 12'hF05;
    do_reset();
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 4'h0);
    n_chk++;
    if (ir_pc !== 4'h5 || ir !== 12'hF05 || !ir_valid)
      $display("FAIL halt_deliver: pc=%h ir=%h v=%b want pc=5 ir=F05 v=1",
               ir_pc, ir, ir_valid);
    else n_pass++;
`ifdef FETCH_HALT_EN
    n_chk++;
    if (halted !== 1'b1)
      $display("FAIL halt_flag: halted=%b want 1", halted);
    else n_pass++;
    tick(1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b0, 4'h0);
    n_chk++;
    if (ir_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 4'h5)
      $display("FAIL halt_drain: v=%b h=%b a=%h want v=0 h=1 a=5",
               ir_valid, halted, rom_addr);
    else n_pass++;
    tick(1'b1, 1'b1, 4'h0);
    n_chk++;
    if (halted !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL halt_clear: h=%b v=%b want h=0 v=0", halted, ir_valid);
    else n_pass++;
    tick(1'b1, 1'b0, 4'h0);
    n_chk++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'h0)
      $display("FAIL halt_resume: v=%b pc=%h want v=1 pc=0", ir_valid, ir_pc);
    else n_pass++;
`else
    tick(1'b1, 1'b0, 4'h0);
    n_chk++;
    if (halted !== 1'b0 || ir_pc !== 4'h6 || !ir_valid)
      $display("FAIL nohalt_continue: h=%b pc=%h v=%b want h=0 pc=6 v=1",
               halted, ir_pc, ir_valid);
    else n_pass++;
`endif
    load_prog();
  endtask

  task automatic test_async_reset();
    load_prog();
    rom[1] = 12'hF01;
    do_reset();
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    n_chk++;
    if (halted !== m_halt || ir_valid !== 1'b1 || rom_addr !== m_pc)
      $display("FAIL areset_pre: h=%b v=%b a=%h want h=%b v=1 a=%h",
               halted, ir_valid, rom_addr, m_halt, m_pc);
    else n_pass++;
    #3;
    n_reset = 1'b0;
    #1;
    n_chk++;
    if (ir_valid !== 1'b0 || halted !== 1'b0 || rom_addr !== 4'h0)
      $display("FAIL areset_now: v=%b h=%b a=%h want 0 0 0",
               ir_valid, halted, rom_addr);
    else n_pass++;
    load_prog();
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    m_q.delete();
    m_pc = 4'h0;
    m_halt = 1'b0;
    tick(1'b1, 1'b0, 4'h0);
    n_chk++;
    if (ir_valid !== 1'b1 || ir_pc !== 4'h0 || ir !== 12'h700)
      $display("FAIL areset_restart: v=%b pc=%h ir=%h want 1 0 700",
               ir_valid, ir_pc, ir);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] eir;
    logic [3:0]  epc;
    int bad;
    for (int i = 0; i < 16; i++) rom[i] = 12'($urandom);
    rom[3] = 12'hF03;
    do_reset();
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)));
      eir = (m_q.size() != 0) ? m_q[0][11:0] : 12'h0;
      epc = (m_q.size() != 0) ? m_q[0][15:12] : 4'h0;
      n_chk++;
      if (ir_valid !== (m_q.size() != 0) || ir !== eir || ir_pc !== epc
          || rom_addr !== m_pc || halted !== m_halt) begin
        bad++;
        if (bad < 10)
          $display("FAIL random_c%0d: v=%b ir=%h pc=%h a=%h h=%b want v=%b ir=%h pc=%h a=%h h=%b",
                   c, ir_valid, ir, ir_pc, rom_addr, halted,
                   m_q.size() != 0, eir, epc, m_pc, m_halt);
      end else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_reset = 1'b1;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 4'h0;
    m_pc = 4'h0;
    m_halt = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
